// File: rtl/hack_cpu_mc.sv
// hack_cpu_mc: multicycle Hack CPU with ready/valid instruction and data ports.
// Define HACK_CPU_HALT_EN to freeze the core in HALT after a taken self-jump.
module hack_cpu_mc #(
  parameter int DATA_W = 16,
  parameter int PC_W   = 16,
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              nrst,
  output logic [PC_W-1:0]   inst_addr,
  output logic              inst_req,
  input  logic [15:0]       inst,
  input  logic              inst_valid,
  output logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] rdata,
  output logic [DATA_W-1:0] wdata,
  output logic              re,
  output logic              we,
  input  logic              data_ready,
  output logic              retired,
  output logic              halted
);

  // state  | meaning
  // FETCH  | request word at pc, latch it into ir
  // MEM_RD | read M[A] into m_q
  // EXEC   | evaluate; commit unless the result goes to M
  // MEM_WR | write ALU result to M[A], commit on data_ready
  // HALT   | taken self-jump seen, frozen until reset
  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    MEM_RD = 3'd1,
    EXEC   = 3'd2,
`ifdef HACK_CPU_HALT_EN
    MEM_WR = 3'd3,
    HALT   = 3'd4
`else
    MEM_WR = 3'd3
`endif
  } state_t;

  state_t            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] d_q, d_d;
  logic [DATA_W-1:0] m_q, m_d;
  logic [15:0]       ir_q, ir_d;

  logic [DATA_W-1:0] alu_x0, alu_x1, alu_y0, alu_y1, alu_f, alu_out;
  logic              alu_neg, alu_zero, alu_pos, jump_taken;
  logic [PC_W-1:0]   jump_tgt, pc_inc;
  logic              commit, req_i, re_i, we_i;

  always_comb begin
    alu_x0   = ir_q[11] ? '0 : d_q;
    alu_x1   = ir_q[10] ? ~alu_x0 : alu_x0;
    alu_y0   = ir_q[9] ? '0 : (ir_q[12] ? m_q : a_q);
    alu_y1   = ir_q[8] ? ~alu_y0 : alu_y0;
    alu_f    = ir_q[7] ? (alu_x1 + alu_y1) : (alu_x1 & alu_y1);
    alu_out  = ir_q[6] ? ~alu_f : alu_f;
    alu_neg  = alu_out[DATA_W-1];
    alu_zero = (alu_out == '0);
    alu_pos  = !alu_neg && !alu_zero;
    jump_taken = ir_q[15] &&
                 ((alu_neg && ir_q[2]) || (alu_zero && ir_q[1]) || (alu_pos && ir_q[0]));
    // Target is A as it stood before this instruction writes it.
    jump_tgt = PC_W'(a_q);
    pc_inc   = pc_q + PC_W'(1);
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    a_d     = a_q;
    d_d     = d_q;
    m_d     = m_q;
    ir_d    = ir_q;
    commit  = 1'b0;
    req_i   = 1'b0;
    re_i    = 1'b0;
    we_i    = 1'b0;

    case (state_q)
      FETCH: begin
        req_i = 1'b1;
        if (inst_valid) begin
          ir_d    = inst;
          state_d = (inst[15] && inst[12]) ? MEM_RD : EXEC;
        end
      end
      MEM_RD: begin
        re_i = 1'b1;
        if (data_ready) begin
          m_d     = rdata;
          state_d = EXEC;
        end
      end
      EXEC: begin
        if (ir_q[15] && ir_q[3]) state_d = MEM_WR;
        else                     commit  = 1'b1;
      end
      MEM_WR: begin
        we_i = 1'b1;
        if (data_ready) commit = 1'b1;
      end
`ifdef HACK_CPU_HALT_EN
      HALT: begin
      end
`endif
      default: state_d = FETCH;
    endcase

    if (commit) begin
      state_d = FETCH;
      if (!ir_q[15]) begin
        a_d  = DATA_W'(ir_q[14:0]);
        pc_d = pc_inc;
      end else begin
        if (ir_q[4]) d_d = alu_out;
        if (ir_q[5]) a_d = alu_out;
        pc_d = jump_taken ? jump_tgt : pc_inc;
`ifdef HACK_CPU_HALT_EN
        if (jump_taken && (jump_tgt == pc_q)) state_d = HALT;
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q <= FETCH;
      pc_q    <= '0;
      a_q     <= '0;
      d_q     <= '0;
      m_q     <= '0;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      a_q     <= a_d;
      d_q     <= d_d;
      m_q     <= m_d;
      ir_q    <= ir_d;
    end
  end

  // Handshake strobes drop in the same cycle reset is applied.
  assign inst_req  = nrst && req_i;
  assign re        = nrst && re_i;
  assign we        = nrst && we_i;
  assign retired   = nrst && commit;
  assign inst_addr = pc_q;
  assign data_addr = a_q[ADDR_W-1:0];
  assign wdata     = alu_out;

`ifdef HACK_CPU_HALT_EN
  assign halted = (state_q == HALT);
`else
  assign halted = 1'b0;
`endif

endmodule
